// File: rtl/set_assoc_icache.sv
// rtl/set_assoc_icache.sv - N-way set-associative instruction cache with round-robin refill
// Optional hit/miss counters are built when ICACHE_PERF_COUNTERS_EN is defined.
module set_assoc_icache #(
   parameter int NFU                     = 2,
   parameter int NWAYS                   = 2,
   parameter int NSETS                   = 128,
   parameter int PHYSICAL_ADDRESS_LENGTH = 56
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [PHYSICAL_ADDRESS_LENGTH-1:0] address,
   input  logic                               doFetch,
   output logic [NFU*32-1:0]                  data,
   output logic                               doneFetch,
   input  logic                               flush,
   output logic                               busy,
   output logic                               doL2Fetch,
   input  logic                               doneL2Fetch,
   output logic [PHYSICAL_ADDRESS_LENGTH-1:0] l2Address,
   input  logic [NFU*32-1:0]                  l2Data,
   output logic [31:0]                        hitCount,
   output logic [31:0]                        missCount
);
   localparam int OFFSET  = $clog2(NFU*4);
   localparam int SETIDX  = $clog2(NSETS);
   localparam int TAGSIZE = PHYSICAL_ADDRESS_LENGTH - SETIDX - OFFSET;
   localparam int LINE    = NFU*32;
   localparam int WAYW    = (NWAYS > 1) ? $clog2(NWAYS) : 1;

   typedef enum logic {IDLE, MISS} state_t;
   state_t state, state_next;

   logic [LINE-1:0]    data_mem   [NWAYS][NSETS];
   logic [TAGSIZE-1:0] tag_mem    [NWAYS][NSETS];
   logic [NWAYS-1:0]   valid      [NSETS];
   logic [WAYW-1:0]    victim_ptr [NSETS];
   logic               flush_pending;

   logic [SETIDX-1:0]  req_set, miss_set;
   logic [TAGSIZE-1:0] req_tag, miss_tag;
   logic               hit, have_invalid;
   logic [WAYW-1:0]    hit_way, victim_way;
   logic               do_flush, do_hit, do_miss, do_fill;
   logic               unused_offset;

   assign req_set       = address[OFFSET +: SETIDX];
   assign req_tag       = address[SETIDX+OFFSET +: TAGSIZE];
   assign unused_offset = ^address[OFFSET-1:0];
   // l2Address doubles as the registered miss address
   assign miss_set      = l2Address[OFFSET +: SETIDX];
   assign miss_tag      = l2Address[SETIDX+OFFSET +: TAGSIZE];
   assign busy          = (state == MISS) | flush_pending;

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < NWAYS; w++) begin
         if (valid[req_set][w] && tag_mem[w][req_set] == req_tag) begin
            hit     = 1'b1;
            hit_way = WAYW'(w);
         end
      end
   end

   // Prefer the lowest-index empty way; fall back to the round-robin pointer
   always_comb begin
      have_invalid = 1'b0;
      victim_way   = victim_ptr[miss_set];
      for (int w = NWAYS-1; w >= 0; w--) begin
         if (!valid[miss_set][w]) begin
            have_invalid = 1'b1;
            victim_way   = WAYW'(w);
         end
      end
   end

   always_comb begin
      state_next = state;
      do_flush   = 1'b0;
      do_hit     = 1'b0;
      do_miss    = 1'b0;
      do_fill    = 1'b0;
      case (state)
         IDLE: begin
            if (flush || flush_pending) begin
               do_flush = 1'b1;
            end else if (doFetch) begin
               if (hit) begin
                  do_hit = 1'b1;
               end else begin
                  do_miss    = 1'b1;
                  state_next = MISS;
               end
            end
         end
         MISS: begin
            if (doneL2Fetch) begin
               do_fill    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         flush_pending <= 1'b0;
         data          <= '0;
         doneFetch     <= 1'b0;
         doL2Fetch     <= 1'b0;
         l2Address     <= '0;
         for (int s = 0; s < NSETS; s++) begin
            valid[s]      <= '0;
            victim_ptr[s] <= '0;
         end
      end else begin
         state     <= state_next;
         doneFetch <= do_hit | do_fill;
         if (do_hit) data <= data_mem[hit_way][req_set];
         if (do_miss) begin
            l2Address <= {address[PHYSICAL_ADDRESS_LENGTH-1:OFFSET], {OFFSET{1'b0}}};
            doL2Fetch <= 1'b1;
         end
         if (state == MISS && flush) flush_pending <= 1'b1;
         else if (do_flush)          flush_pending <= 1'b0;
         if (do_flush) begin
            for (int s = 0; s < NSETS; s++) begin
               valid[s]      <= '0;
               victim_ptr[s] <= '0;
            end
         end
         if (do_fill) begin
            data                         <= l2Data;
            doL2Fetch                    <= 1'b0;
            valid[miss_set][victim_way]  <= 1'b1;
            if (!have_invalid)
               victim_ptr[miss_set] <= (NWAYS > 1) ? victim_ptr[miss_set] + WAYW'(1) : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_fill && !rst) begin
         data_mem[victim_way][miss_set] <= l2Data;
         tag_mem[victim_way][miss_set]  <= miss_tag;
      end
   end

`ifdef ICACHE_PERF_COUNTERS_EN
   logic [31:0] hit_cnt, miss_cnt;
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (do_hit)  hit_cnt  <= hit_cnt + 32'd1;
         if (do_miss) miss_cnt <= miss_cnt + 32'd1;
      end
   end
   assign hitCount  = hit_cnt;
   assign missCount = miss_cnt;
`else
   assign hitCount  = '0;
   assign missCount = '0;
`endif
endmodule

// File: tb/tb_set_assoc_icache.sv
// tb/tb_set_assoc_icache.sv - table vectors, corner sequences and random run against a cache model
module tb_set_assoc_icache;
   localparam int PAL  = 56;
   localparam int LINE = 64;
`ifdef ICACHE_PERF_COUNTERS_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [PAL-1:0]  address = '0;
   logic            doFetch = 1'b0;
   logic [LINE-1:0] data;
   logic            doneFetch;
   logic            flush = 1'b0;
   logic            busy;
   logic            doL2Fetch;
   logic            doneL2Fetch = 1'b0;
   logic [PAL-1:0]  l2Address;
   logic [LINE-1:0] l2Data = '0;
   logic [31:0]     hitCount, missCount;

   int total = 0;
   int bad   = 0;
   int hc    = 0;
   int mc    = 0;

   set_assoc_icache #(.NFU(2), .NWAYS(2), .NSETS(128), .PHYSICAL_ADDRESS_LENGTH(PAL)) dut (
      .clk(clk), .rst(rst), .address(address), .doFetch(doFetch), .data(data),
      .doneFetch(doneFetch), .flush(flush), .busy(busy), .doL2Fetch(doL2Fetch),
      .doneL2Fetch(doneL2Fetch), .l2Address(l2Address), .l2Data(l2Data),
      .hitCount(hitCount), .missCount(missCount)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic chk_counters(input string name);
      chk({name, "_hits"},   hitCount,  PERF ? 64'(hc) : 64'd0);
      chk({name, "_misses"}, missCount, PERF ? 64'(mc) : 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1; doFetch = 1'b0; flush = 1'b0; doneL2Fetch = 1'b0;
      @(negedge clk); rst = 1'b0;
      hc = 0; mc = 0;
   endtask

   // One request through the full handshake; L2 answers dly cycles after the miss is seen
   task automatic request(input logic [PAL-1:0] a, input int dly, input logic [LINE-1:0] fill,
                          output bit hit, output logic [LINE-1:0] d, output logic [PAL-1:0] l2a);
      @(negedge clk); address = a; doFetch = 1'b1;
      @(negedge clk); doFetch = 1'b0;
      hit = doneFetch; d = data; l2a = l2Address;
      chk("req_l2_request", doL2Fetch, !hit);
      if (!hit) begin
         repeat (dly) @(negedge clk);
         chk("req_l2_held", doL2Fetch, 1'b1);
         l2Data = fill; doneL2Fetch = 1'b1;
         @(negedge clk); doneL2Fetch = 1'b0;
         chk("req_fill_done", doneFetch, 1'b1);
         chk("req_l2_dropped", doL2Fetch, 1'b0);
         d = data;
      end
   endtask

   typedef struct {
      logic [PAL-1:0]  addr;
      int              dly;
      logic [LINE-1:0] fill;
      bit              exp_hit;
      logic [LINE-1:0] exp_data;
      logic [PAL-1:0]  exp_l2;
   } vec_t;

   // Reference cache: per set, two ways with tag/line/valid and a replacement pointer
   logic [45:0]     m_tag   [128][2];
   logic [LINE-1:0] m_data  [128][2];
   bit              m_valid [128][2];
   int              m_ptr   [128];

   task automatic model_clear();
      for (int s = 0; s < 128; s++) begin
         m_ptr[s] = 0;
         for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
      end
   endtask

   initial begin
      vec_t            vecs[9];
      bit              gh, eh;
      logic [LINE-1:0] gd, ed;
      logic [PAL-1:0]  gl, a;

      vecs[0] = '{56'h1000, 3, 64'hA, 1'b0, 64'hA, 56'h1000};
      vecs[1] = '{56'h1000, 0, 64'h0, 1'b1, 64'hA, 56'h0};
      vecs[2] = '{56'h1400, 1, 64'hB, 1'b0, 64'hB, 56'h1400};
      vecs[3] = '{56'h1800, 2, 64'hC, 1'b0, 64'hC, 56'h1800};
      vecs[4] = '{56'h1000, 0, 64'hD, 1'b0, 64'hD, 56'h1000};
      vecs[5] = '{56'h1800, 0, 64'h0, 1'b1, 64'hC, 56'h0};
      vecs[6] = '{56'h1400, 1, 64'hE, 1'b0, 64'hE, 56'h1400};
      vecs[7] = '{56'h1004, 0, 64'h0, 1'b1, 64'hD, 56'h0};
      vecs[8] = '{56'h1807, 0, 64'hF, 1'b0, 64'hF, 56'h1800};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_done", doneFetch, 1'b0);
      chk("rst_l2req", doL2Fetch, 1'b0);
      chk("rst_l2addr", l2Address, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_data", data, '0);
      chk_counters("rst");

      for (int i = 0; i < 9; i++) begin
         request(vecs[i].addr, vecs[i].dly, vecs[i].fill, gh, gd, gl);
         chk($sformatf("vec%0d_hit", i), gh, vecs[i].exp_hit);
         chk($sformatf("vec%0d_data", i), gd, vecs[i].exp_data);
         if (!vecs[i].exp_hit) chk($sformatf("vec%0d_l2addr", i), gl, vecs[i].exp_l2);
         if (vecs[i].exp_hit) hc++; else mc++;
         if (i == 1) chk_counters("vec1");
      end
      chk_counters("table");

      // held doFetch on a resident line gives a completion every cycle
      @(negedge clk); address = 56'h1400; doFetch = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("b2b_done", doneFetch, 1'b1);
         chk("b2b_data", data, 64'hE);
      end
      doFetch = 1'b0; hc += 3;

      // stray L2 response while idle
      @(negedge clk); doneL2Fetch = 1'b1; l2Data = 64'h55;
      @(negedge clk); doneL2Fetch = 1'b0;
      chk("idle_l2_done", doneFetch, 1'b0);
      chk("idle_l2_busy", busy, 1'b0);

      request(56'h1007, 0, 64'h77, gh, gd, gl);
      chk("unaligned_hit", gh, 1'b0);
      chk("unaligned_l2addr", gl, 56'h1000);
      mc++;

      // flush beats a simultaneous fetch
      @(negedge clk); flush = 1'b1; address = 56'h1000; doFetch = 1'b1;
      @(negedge clk); flush = 1'b0; doFetch = 1'b0;
      chk("flush_idle_done", doneFetch, 1'b0);
      chk("flush_idle_l2req", doL2Fetch, 1'b0);

      // flush during a miss is deferred until just after the fill
      @(negedge clk); address = 56'h1000; doFetch = 1'b1;
      @(negedge clk); doFetch = 1'b0;
      chk("fmiss_l2req", doL2Fetch, 1'b1);
      flush = 1'b1;
      @(negedge clk); flush = 1'b0; l2Data = 64'h99; doneL2Fetch = 1'b1;
      @(negedge clk); doneL2Fetch = 1'b0;
      chk("fmiss_done", doneFetch, 1'b1);
      chk("fmiss_data", data, 64'h99);
      chk("fmiss_busy", busy, 1'b1);
      @(negedge clk);
      chk("fmiss_busy_clear", busy, 1'b0);
      mc++;
      request(56'h1000, 1, 64'h98, gh, gd, gl);
      chk("fmiss_refetch_hit", gh, 1'b0);
      chk("fmiss_refetch_data", gd, 64'h98);
      mc++;
      chk_counters("pre_rst");

      // reset in the middle of a miss drops it
      @(negedge clk); address = 56'h1400; doFetch = 1'b1;
      @(negedge clk); doFetch = 1'b0;
      chk("rmiss_l2req", doL2Fetch, 1'b1);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0; hc = 0; mc = 0;
      chk("rmiss_l2req_low", doL2Fetch, 1'b0);
      chk("rmiss_busy", busy, 1'b0);
      doneL2Fetch = 1'b1; l2Data = 64'h44;
      @(negedge clk); doneL2Fetch = 1'b0;
      chk("rmiss_late_done", doneFetch, 1'b0);
      chk_counters("rmiss");

      // randomized traffic against the reference cache
      do_reset();
      model_clear();
      for (int it = 0; it < 250; it++) begin
         a = (56'($urandom_range(4, 7)) << 10) | (56'($urandom_range(0, 3)) << 3) | 56'($urandom_range(0, 7));
         if ($urandom_range(0, 11) == 0) begin
            @(negedge clk); flush = 1'b1; address = a; doFetch = 1'($urandom_range(0, 1));
            @(negedge clk); flush = 1'b0; doFetch = 1'b0;
            chk("rnd_flush_done", doneFetch, 1'b0);
            model_clear();
         end else begin
            int          s, vw;
            logic [45:0] t;
            logic [LINE-1:0] fill;
            s = int'((a >> 3) % 128);
            t = 46'(a >> 10);
            eh = 1'b0; ed = '0;
            for (int w = 0; w < 2; w++)
               if (m_valid[s][w] && m_tag[s][w] == t) begin eh = 1'b1; ed = m_data[s][w]; end
            fill = {$urandom, $urandom};
            request(a, $urandom_range(0, 3), fill, gh, gd, gl);
            chk("rnd_hit", gh, eh);
            if (eh) begin
               chk("rnd_hit_data", gd, ed);
               hc++;
            end else begin
               chk("rnd_fill_data", gd, fill);
               chk("rnd_l2addr", gl, a & ~56'h7);
               mc++;
               if (!m_valid[s][0])      vw = 0;
               else if (!m_valid[s][1]) vw = 1;
               else begin
                  vw = m_ptr[s];
                  m_ptr[s] = (m_ptr[s] + 1) % 2;
               end
               m_valid[s][vw] = 1'b1; m_tag[s][vw] = t; m_data[s][vw] = fill;
            end
         end
      end
      @(negedge clk);
      chk_counters("rnd_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/set_assoc_icache.md
# set_assoc_icache

Parametrised N-way set-associative instruction cache, successor to the direct-mapped instruction cache. It sits between the fetch stage and the L2 cache controller and returns one full fetch line (NFU × 32-bit instructions) per request. Over the direct-mapped block it adds configurable associativity with per-set round-robin replacement, registered miss address, synchronous reset that clears all tags, a single-cycle flush, and optional hit/miss counters.

## Interface
Parameters:
- NFU, 2, functional units; line = NFU×32 bits
- NWAYS, 2, ways per set (power of two, ≥1)
- NSETS, 128, sets (power of two)
- PHYSICAL_ADDRESS_LENGTH, 56, physical address width
- derived: OFFSET=$clog2(NFU*4), SETIDX=$clog2(NSETS), TAGSIZE=PHYSICAL_ADDRESS_LENGTH−SETIDX−OFFSET, LINE=NFU*32

Ports (one clock `clk`; reset `rst`, synchronous, active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- address  in  PHYSICAL_ADDRESS_LENGTH  fetch address; tag = [SETIDX+OFFSET +: TAGSIZE], set = [OFFSET +: SETIDX]
- doFetch  in  1  fetch request, sampled in IDLE only
- data  out  LINE  returned line, valid when doneFetch=1
- doneFetch  out  1  one-cycle completion per request
- flush  in  1  invalidate all lines
- busy  out  1  high when not IDLE
- doL2Fetch  out  1  L2 request, held until doneL2Fetch
- doneL2Fetch  in  1  L2 response valid
- l2Address  out  PHYSICAL_ADDRESS_LENGTH  line-aligned miss address (offset bits zero)
- l2Data  in  LINE  L2 fill line
- hitCount, missCount  out  32  performance counters (see Configuration)

## Operation
- Storage: per way, data array [NSETS][LINE], tag array [NSETS][TAGSIZE], valid flops [NSETS][NWAYS]; per set, victim pointer of $clog2(NWAYS) bits (0 width handled for NWAYS=1).
- FSM: IDLE, MISS.
- IDLE, flush=1: clear all valid bits and victim pointers; doFetch that cycle ignored (flush wins); stay IDLE.
- IDLE, doFetch=1, hit (any way valid with matching tag; at most one by construction): data<=that way's line, doneFetch<=1, stay IDLE.
- IDLE, doFetch=1, miss: latch address into miss register, l2Address<=address with OFFSET bits zeroed, doL2Fetch<=1, doneFetch<=0, go MISS.
- IDLE otherwise: doneFetch<=0.
- MISS: doFetch ignored; doL2Fetch held 1, l2Address stable. On doneL2Fetch=1: victim = lowest-index invalid way in the miss set, else victim pointer; write tag, line, valid=1; if pointer used, pointer<=pointer+1 (mod NWAYS); data<=l2Data, doneFetch<=1, doL2Fetch<=0, go IDLE.
- flush during MISS: latched as pending; applied in the cycle after the fill completes (line just filled is invalidated); busy remains 1 that cycle.
- doneL2Fetch while IDLE: ignored.

## Timing
- Reset values: data=0, doneFetch=0, doL2Fetch=0, l2Address=0, busy=0, all valid=0, pointers=0, counters=0, state IDLE, pending flush=0.
- Hit: doFetch sampled at edge N → doneFetch/data valid after N (1 cycle). Held doFetch with hits gives back-to-back doneFetch every cycle.
- Miss: doFetch at edge N → doL2Fetch=1 after N; doneL2Fetch sampled at edge M → doneFetch=1, doL2Fetch=0 after M. Earliest next request sampled at edge M+1.
- Requester must treat doneFetch as belonging to the address presented when the request was accepted.
- rst mid-MISS: IDLE next cycle, doL2Fetch=0, no fill; a late doneL2Fetch is ignored.

## Configuration
- ICACHE_PERF_COUNTERS_EN defined: hitCount increments on each IDLE hit, missCount on each IDLE miss; 32-bit, wrap 0xFFFFFFFF→0; cleared by rst only, not flush.
- Undefined: counters not built; hitCount and missCount tied to 0.

## Test plan
NFU=2, NWAYS=2, NSETS=128 (0x1000, 0x1400, 0x1800 all map to set 0):
- Reset then fetch 0x1000, L2 returns 0xA after 3 cycles → doL2Fetch with l2Address=0x1000, doneFetch=1 with data=0xA one cycle after doneL2Fetch.
- Fetch 0x1000 again → doneFetch next cycle, data=0xA, no doL2Fetch; missCount=1, hitCount=1 (counters enabled).
- Fill 0x1400 (0xB), then 0x1800 (0xC) → evicts way0; fetch 0x1000 misses and evicts way1; fetch 0x1800 hits data=0xC.
- Fetch 0x1007 miss → l2Address=0x1000.
- flush asserted during MISS for 0x1000 → fill completes (doneFetch, data), busy=1 next cycle, subsequent 0x1000 misses.
- rst asserted one cycle after doL2Fetch rises → doL2Fetch=0, doneL2Fetch next cycle produces no doneFetch, counters=0.
